// File: rtl/song_recorder.sv
// song_recorder
//   Records a live note stream into an on-chip note RAM, one entry per beat,
//   and plays the stored sequence back as a 6-bit note code stream. This block
//   writes the track input of the song driver. Note code 0 is a rest.
//
// Ports
//   EGO1_Clock  in   system clock
//   reset       in   asynchronous, active-high reset
//   key_note    in   [5:0] live note code from the keypad decoder
//   rec_start   in   one-cycle pulse: begin a new recording
//   play_start  in   one-cycle pulse: begin playback (ignored when empty)
//   stop        in   one-cycle pulse: abort record/play
//   loop_en     in   level: playback wraps to entry 0 at the end
//   track_out   out  [5:0] note code to the song driver
//   mode        out  [1:0] FSM state: 00 IDLE, 01 RECORD, 10 PLAY
//   rec_len     out  [ADDR_W:0] number of valid stored beats
//   full        out  sticky: a recording filled every RAM entry
//   done        out  one-cycle pulse when a non-looping playback ends
//
// Handshake: there is no valid/ready flow control. Commands are single-cycle
// pulses sampled on every rising edge in every mode, with priority
// stop > rec_start > play_start; track_out is a free-running registered stream.
module song_recorder #(
    parameter int ADDR_W   = 8,
    parameter int BEAT_DIV = 6250000
) (
    input  logic              EGO1_Clock,
    input  logic              reset,
    input  logic [5:0]        key_note,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [5:0]        track_out,
    output logic [1:0]        mode,
    output logic [ADDR_W:0]   rec_len,
    output logic              full,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEAT_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic              tick;
    logic              entry;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_next;
    logic [ADDR_W:0]   rec_len_next;
    logic              full_next;
    logic              done_next;

    logic [5:0] mem [DEPTH];

    // The FSM state is exported directly as the mode output.
    assign mode = state;

    assign tick = (state != IDLE) && (beat_cnt == LAST_CNT);

    // State register
    always_ff @(posedge EGO1_Clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state, pointer and status logic
    always_comb begin
        state_next   = state;
        entry        = 1'b0;
        wr_en        = 1'b0;
        wr_ptr_next  = wr_ptr;
        rd_ptr_next  = rd_ptr;
        rec_len_next = rec_len;
        full_next    = full;
        done_next    = 1'b0;

        if (stop) begin
            // Stop outranks a coincident tick, so no write is made.
            state_next = IDLE;
        end else if (rec_start) begin
            state_next   = RECORD;
            entry        = 1'b1;
            wr_ptr_next  = '0;
            rec_len_next = '0;
            full_next    = 1'b0;
        end else if (play_start && (state != RECORD) && (rec_len != '0)) begin
            state_next  = PLAY;
            entry       = 1'b1;
            rd_ptr_next = '0;
        end else begin
            case (state)
                RECORD: begin
                    if (tick) begin
                        wr_en        = 1'b1;
                        rec_len_next = {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
                        if (wr_ptr == LAST_ADDR) begin
                            // RAM filled: stop recording rather than wrap.
                            full_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            wr_ptr_next = wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if ({1'b0, rd_ptr} == rec_len - (ADDR_W + 1)'(1)) begin
                            if (loop_en) begin
                                rd_ptr_next = '0;
                            end else begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                            end
                        end else begin
                            rd_ptr_next = rd_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat counter: held at 0 while idle and restarted on every mode entry,
    // so the first tick lands BEAT_DIV cycles after entry.
    always_ff @(posedge EGO1_Clock or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if ((state == IDLE) || entry || tick) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Pointers and status
    always_ff @(posedge EGO1_Clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rec_len <= '0;
            full    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            rec_len <= rec_len_next;
            full    <= full_next;
            done    <= done_next;
        end
    end

    // Note RAM write port; contents survive reset.
    always_ff @(posedge EGO1_Clock) begin
        if (wr_en) mem[wr_ptr] <= key_note;
    end

    // Output register doubles as the synchronous RAM read port in PLAY and
    // as a one-cycle-delayed monitor of key_note in RECORD.
    always_ff @(posedge EGO1_Clock or posedge reset) begin
        if (reset) begin
            track_out <= '0;
        end else begin
            case (state)
                RECORD:  track_out <= key_note;
                PLAY:    track_out <= mem[rd_ptr];
                default: track_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_song_recorder.sv
module tb_song_recorder;

  localparam int ADDR_W = 3;
  localparam int BEAT   = 4;

  logic              clk;
  logic              rst;
  logic [5:0]        key_note;
  logic              rec_start;
  logic              play_start;
  logic              stop;
  logic              loop_en;
  logic [5:0]        track_out;
  logic [1:0]        mode;
  logic [ADDR_W:0]   rec_len;
  logic              full;
  logic              done;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_q[$];
  logic [5:0] song[16];
  int         song_len;

  song_recorder #(
    .ADDR_W   (ADDR_W),
    .BEAT_DIV (BEAT)
  ) dut (
    .EGO1_Clock (clk),
    .reset      (rst),
    .key_note   (key_note),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .loop_en    (loop_en),
    .track_out  (track_out),
    .mode       (mode),
    .rec_len    (rec_len),
    .full       (full),
    .done       (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard for the track_out stream
  task automatic push_track(input logic [5:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_track(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%0d expected=<scoreboard empty>", tag, track_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, track_out, e);
    end
  endtask

  task automatic pulse_play();
    play_start = 1'b1;
    step();
    play_start = 1'b0;
  endtask

  // Play song[0..song_len-1] for the given number of passes, starting right
  // after the entry edge. Without loop the final beat ends with done.
  task automatic play_run(input string tag, input int passes, input bit lp);
    int total;
    total = song_len * BEAT * passes;
    for (int i = 1; i <= total; i++) begin
      push_track(song[((i - 1) / BEAT) % song_len]);
      step();
      pop_track({tag, "_track"});
      check({tag, "_done"}, done, (!lp && i == total) ? 1 : 0);
      check({tag, "_mode"}, mode, (!lp && i == total) ? 0 : 2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    key_note   = '0;
    rec_start  = 1'b0;
    play_start = 1'b0;
    stop       = 1'b0;
    loop_en    = 1'b0;

    step();
    step();
    check("rst_mode", mode, 0);
    check("rst_track", track_out, 0);
    check("rst_len", rec_len, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Empty playback is ignored
    pulse_play();
    check("empty_play_mode", mode, 0);
    step();
    check("empty_play_mode2", mode, 0);

    // Basic record: 5,12,0,33
    song[0] = 6'd5; song[1] = 6'd12; song[2] = 6'd0; song[3] = 6'd33;
    song_len = 4;
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    check("rec_mode", mode, 1);
    for (int k = 0; k < 4; k++) begin
      key_note = song[k];
      check("rec_lag", track_out, (k == 0) ? 0 : song[k - 1]);
      for (int c = 0; c < BEAT; c++) begin
        push_track(song[k]);
        step();
        pop_track("rec_echo");
      end
      check("rec_len_prog", rec_len, k + 1);
    end
    key_note = 6'd7;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("rec_stop_mode", mode, 0);
    check("rec_len", rec_len, 4);
    check("rec_full", full, 0);
    step();
    check("rec_idle_track", track_out, 0);

    // Playback without loop
    loop_en = 1'b0;
    pulse_play();
    check("play_entry_mode", mode, 2);
    play_run("play", 1, 1'b0);
    step();
    check("play_end_track", track_out, 0);
    check("play_end_done", done, 0);
    check("play_end_mode", mode, 0);

    // Playback with loop, three passes then stop
    loop_en = 1'b1;
    pulse_play();
    check("loop_entry_mode", mode, 2);
    play_run("loop", 3, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_mode", mode, 0);
    check("loop_stop_done", done, 0);
    step();
    check("loop_stop_track", track_out, 0);
    check("loop_stop_done2", done, 0);
    loop_en = 1'b0;

    // Stop coincident with a tick: no write
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    key_note = 6'd9;
    for (int c = 0; c < BEAT; c++) step();
    check("st_len1", rec_len, 1);
    key_note = 6'd10;
    for (int c = 0; c < BEAT - 1; c++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("st_mode", mode, 0);
    check("st_len", rec_len, 1);

    // rec_start + play_start together enters RECORD; then fill to DEPTH
    rec_start  = 1'b1;
    play_start = 1'b1;
    step();
    rec_start  = 1'b0;
    play_start = 1'b0;
    check("prio_mode", mode, 1);
    check("prio_len", rec_len, 0);
    for (int b = 0; b < 10; b++) begin
      key_note = 6'(20 + b);
      for (int c = 0; c < BEAT; c++) begin
        if (b < 8) push_track(6'(20 + b));
        step();
        if (b < 8) pop_track("full_echo");
      end
      if (b < 8) begin
        check("full_len_prog", rec_len, b + 1);
        check("full_flag_prog", full, (b == 7) ? 1 : 0);
        check("full_mode_prog", mode, (b == 7) ? 0 : 1);
      end
    end
    check("full_len", rec_len, 8);
    check("full_flag", full, 1);
    check("full_mode", mode, 0);
    check("full_track", track_out, 0);

    // Play the full recording: 20..27 only
    for (int i = 0; i < 8; i++) song[i] = 6'(20 + i);
    song_len = 8;
    pulse_play();
    check("fplay_entry_mode", mode, 2);
    play_run("fplay", 1, 1'b0);
    step();
    check("fplay_end_track", track_out, 0);

    // Asynchronous reset mid-play
    pulse_play();
    for (int i = 1; i <= 6; i++) begin
      push_track(song[(i - 1) / BEAT]);
      step();
      pop_track("rp_track");
    end
    check("rp_pre_mode", mode, 2);
    #3;
    rst = 1'b1;
    #1;
    check("rp_track", track_out, 0);
    check("rp_mode", mode, 0);
    check("rp_len", rec_len, 0);
    check("rp_full", full, 0);
    check("rp_done", done, 0);
    step();
    rst = 1'b0;
    step();
    pulse_play();
    check("rp_noplay_mode", mode, 0);

    check("sb_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
